ecc_op_sequencer: RTL and testbench

ECC_OP_SEQUENCER -- requirements
Module: ecc_op_sequencer

---
 rtl/ecc_op_sequencer.sv | 133 +++++++++++++
 tb/tb_ecc_op_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_op_sequencer.sv
// Sequences encode / decode / full-channel operations over a shared ECC encoder and decoder.
// Results, error status and a saturating completion counter are held in registers.
module ecc_op_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            ctrl,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] noise,
  output logic [DATA_WIDTH-1:0] enc_data,
  input  logic [DATA_WIDTH-1:0] enc_codeword,
  output logic [DATA_WIDTH-1:0] dec_codeword,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic [1:0]            dec_num_of_errors,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  output logic                  operation_done,
  output logic                  op_error,
  output logic [15:0]           ops_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  state_t                state_q, state_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [DATA_WIDTH-1:0] codeword_q, codeword_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            num_err_q, num_err_d;
  logic                  op_error_q, op_error_d;
  logic [15:0]           ops_count_q, ops_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= OP_ENC;
      data_q      <= '0;
      noise_q     <= '0;
      codeword_q  <= '0;
      data_out_q  <= '0;
      num_err_q   <= 2'b00;
      op_error_q  <= 1'b0;
      ops_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      noise_q     <= noise_d;
      codeword_q  <= codeword_d;
      data_out_q  <= data_out_d;
      num_err_q   <= num_err_d;
      op_error_q  <= op_error_d;
      ops_count_q <= ops_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    noise_d     = noise_q;
    codeword_d  = codeword_q;
    data_out_d  = data_out_q;
    num_err_d   = num_err_q;
    op_error_d  = 1'b0;
    ops_count_d = ops_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (ctrl == OP_ILL) begin
            op_error_d = 1'b1;
          end else begin
            ctrl_d  = ctrl;
            data_d  = data_in;
            noise_d = noise;
            state_d = (ctrl == OP_DEC) ? DEC : ENC;
          end
        end
      end
      ENC: begin
        codeword_d = enc_codeword;
        if (ctrl_q == OP_FULL) begin
          state_d = DEC;
        end else begin
          // Publishing here makes the result visible during the DONE cycle.
          data_out_d = enc_codeword;
          num_err_d  = 2'b00;
          state_d    = DONE;
        end
      end
      DEC: begin
        data_out_d = dec_data;
        num_err_d  = dec_num_of_errors;
        state_d    = DONE;
      end
      DONE: begin
        if (ops_count_q != 16'hFFFF) begin
          ops_count_d = ops_count_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enc_data     = (state_q == ENC) ? data_q : '0;
  // Full channel feeds the decoder the corrupted codeword; plain decode uses the operand as-is.
  assign dec_codeword = (state_q != DEC)     ? '0 :
                        (ctrl_q == OP_FULL)  ? (codeword_q ^ noise_q) : data_q;

  assign busy           = (state_q != IDLE);
  assign operation_done = (state_q == DONE);
  assign op_error       = op_error_q;
  assign data_out       = data_out_q;
  assign num_of_errors  = num_err_q;
  assign ops_count      = ops_count_q;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Directed bench for ecc_op_sequencer with an extended-Hamming (SECDED) encoder/decoder model.
// Codeword bit 0 is overall parity, bits 1/2/4/8/16 are Hamming parity, the rest carry data.
module tb_ecc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  ctrl;
  logic [31:0] data_in;
  logic [31:0] noise;
  logic [31:0] enc_data;
  logic [31:0] enc_codeword;
  logic [31:0] dec_codeword;
  logic [31:0] dec_data;
  logic [1:0]  dec_num_of_errors;
  logic        busy;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        operation_done;
  logic        op_error;
  logic [15:0] ops_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecc_op_sequencer #(.DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .ctrl              (ctrl),
    .data_in           (data_in),
    .noise             (noise),
    .enc_data          (enc_data),
    .enc_codeword      (enc_codeword),
    .dec_codeword      (dec_codeword),
    .dec_data          (dec_data),
    .dec_num_of_errors (dec_num_of_errors),
    .busy              (busy),
    .data_out          (data_out),
    .num_of_errors     (num_of_errors),
    .operation_done    (operation_done),
    .op_error          (op_error),
    .ops_count         (ops_count)
  );

  function automatic logic [31:0] ham_enc(input logic [31:0] d);
    logic [31:0] cw;
    logic [4:0]  syn;
    int          k;
    cw  = '0;
    syn = '0;
    k   = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 32; p++) if (cw[p]) syn ^= p[4:0];
    for (int b = 0; b < 5; b++) if (syn[b]) cw[1 << b] = 1'b1;
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  function automatic logic [33:0] ham_dec(input logic [31:0] cw_in);
    logic [31:0] cw;
    logic [31:0] d;
    logic [4:0]  syn;
    logic [1:0]  err;
    int          k;
    cw  = cw_in;
    syn = '0;
    for (int p = 1; p < 32; p++) if (cw[p]) syn ^= p[4:0];
    if (^cw) begin
      err = 2'b01;
      cw[syn] = ~cw[syn];
    end else if (syn != 5'd0) begin
      err = 2'b10;
    end else begin
      err = 2'b00;
    end
    d = '0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p];
        k++;
      end
    end
    return {err, d};
  endfunction

  assign enc_codeword                  = ham_enc(enc_data);
  assign {dec_num_of_errors, dec_data} = ham_dec(dec_codeword);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; waits (bounded) for operation_done, then checks latency, result and pulse width.
  task automatic run_op(input string tag, input logic [1:0] c, input logic [31:0] d,
                        input logic [31:0] n, input int exp_lat,
                        input logic [31:0] exp_data, input logic [1:0] exp_err);
    int lat;
    start   = 1'b1;
    ctrl    = c;
    data_in = d;
    noise   = n;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!operation_done && lat < 6) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data_out"}, data_out, exp_data);
    chk({tag, " num_of_errors"}, {30'd0, num_of_errors}, {30'd0, exp_err});
    tick();
    chk({tag, " done width"}, {31'd0, operation_done}, 32'd0);
    $display("op %s ctrl=%b data_in=%h noise=%h -> lat=%0d data_out=%h err=%b ops=%0d",
             tag, c, d, n, lat, data_out, num_of_errors, ops_count);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ctrl    = 2'b00;
    data_in = '0;
    noise   = '0;
    tick();
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst num_of_errors", {30'd0, num_of_errors}, 32'd0);
    chk("rst ops_count", {16'd0, ops_count}, 32'd0);
    chk("rst done", {31'd0, operation_done}, 32'd0);
    chk("rst op_error", {31'd0, op_error}, 32'd0);
    rst = 1'b0;
    tick();

    // Encode A5: hand-computed codeword 0x144E; inspect the ENC cycle too.
    start   = 1'b1;
    ctrl    = 2'b00;
    data_in = 32'h0000_00A5;
    noise   = 32'h0;
    tick();
    start = 1'b0;
    chk("enc busy", {31'd0, busy}, 32'd1);
    chk("enc enc_data", enc_data, 32'h0000_00A5);
    chk("enc dec_codeword idle", dec_codeword, 32'h0);
    tick();
    chk("enc done", {31'd0, operation_done}, 32'd1);
    chk("enc data_out", data_out, 32'h0000_144E);
    chk("enc num_of_errors", {30'd0, num_of_errors}, 32'd0);
    tick();
    chk("enc enc_data idle", enc_data, 32'h0);
    chk("enc ops_count", {16'd0, ops_count}, 32'd1);
    $display("op encode A5 -> data_out=%h ops=%0d", data_out, ops_count);

    run_op("full single", 2'b10, 32'h0000_00A5, 32'h0000_0004, 3, 32'h0000_00A5, 2'b01);
    run_op("full double", 2'b10, 32'h0000_00A5, 32'h0000_0006, 3, 32'h0000_00A5, 2'b10);
    run_op("decode clean", 2'b01, 32'h0000_144E, 32'hFFFF_FFFF, 2, 32'h0000_00A5, 2'b00);
    run_op("decode bit5", 2'b01, 32'h0000_146E, 32'h0, 2, 32'h0000_00A5, 2'b01);
    run_op("encode 1", 2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 2, 32'h0000_000F, 2'b00);
    chk("ops after six", {16'd0, ops_count}, 32'd6);

    // Illegal request: op_error pulse only.
    start = 1'b1;
    ctrl  = 2'b11;
    tick();
    start = 1'b0;
    chk("ill op_error", {31'd0, op_error}, 32'd1);
    chk("ill busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ill op_error width", {31'd0, op_error}, 32'd0);
    chk("ill ops_count", {16'd0, ops_count}, 32'd6);
    chk("ill data_out kept", data_out, 32'h0000_000F);
    $display("op illegal -> ops=%0d data_out=%h", ops_count, data_out);

    // Start held high while busy with different operands: must be ignored.
    start   = 1'b1;
    ctrl    = 2'b10;
    data_in = 32'h0000_00A5;
    noise   = 32'h0;
    tick();
    ctrl    = 2'b00;
    data_in = 32'h0000_0001;
    noise   = 32'hFFFF_FFFF;
    tick();
    chk("busy start dec_codeword", dec_codeword, 32'h0000_144E);
    start = 1'b0;
    tick();
    chk("busy start done", {31'd0, operation_done}, 32'd1);
    chk("busy start data_out", data_out, 32'h0000_00A5);
    begin
      int extra = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (operation_done) extra++;
      end
      chk("busy start extra dones", extra, 32'd0);
    end
    chk("busy start ops_count", {16'd0, ops_count}, 32'd7);
    $display("op busy-start full A5 -> data_out=%h ops=%0d", data_out, ops_count);

    // Reset during DEC of a full-channel op, with start also high: reset wins.
    start   = 1'b1;
    ctrl    = 2'b10;
    data_in = 32'h0000_00A5;
    noise   = 32'h0000_0004;
    tick();
    start = 1'b0;
    tick();
    chk("abort in DEC", dec_codeword, 32'h0000_144A);
    rst   = 1'b1;
    start = 1'b1;
    ctrl  = 2'b00;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, operation_done}, 32'd0);
    chk("abort data_out", data_out, 32'h0);
    chk("abort ops_count", {16'd0, ops_count}, 32'd0);
    chk("abort dec_codeword", dec_codeword, 32'h0);
    tick();
    chk("abort no late done", {31'd0, operation_done}, 32'd0);
    chk("abort stays idle", {31'd0, busy}, 32'd0);
    $display("op reset-abort -> busy=%b ops=%0d", busy, ops_count);
    run_op("post-abort encode", 2'b00, 32'h0000_00A5, 32'h0, 2, 32'h0000_144E, 2'b00);
    chk("post-abort ops_count", {16'd0, ops_count}, 32'd1);

    // Saturation: preset the counter just below the limit.
    force dut.ops_count_q = 16'hFFFE;
    #1;
    release dut.ops_count_q;
    chk("preset ops_count", {16'd0, ops_count}, 32'h0000_FFFE);
    run_op("sat encode 1", 2'b00, 32'h0000_0001, 32'h0, 2, 32'h0000_000F, 2'b00);
    chk("sat reach", {16'd0, ops_count}, 32'h0000_FFFF);
    run_op("sat encode 2", 2'b00, 32'h0000_00A5, 32'h0, 2, 32'h0000_144E, 2'b00);
    chk("sat hold", {16'd0, ops_count}, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
